// File: rtl/fb_wr_arbiter.sv
// Frame-buffer row write arbiter: init generator during INIT,
// round-robin gen/edit during RUN, writes gated to de=0 blanking.
module fb_wr_arbiter #(
    parameter int DW   = 100,
    parameter int AW   = 7,
    parameter int ROWS = 100
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          de,
    input  logic          init_req,
    input  logic          gen_req,
    input  logic          edit_req,
    input  logic [AW-1:0] init_addr,
    input  logic [AW-1:0] gen_addr,
    input  logic [AW-1:0] edit_addr,
    input  logic [DW-1:0] init_data,
    input  logic [DW-1:0] gen_data,
    input  logic [DW-1:0] edit_data,
    input  logic          init_done,
    output logic          init_ack,
    output logic          gen_ack,
    output logic          edit_ack,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data,
    output logic          init_rdy,
    output logic          addr_err
);

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic PTR_GEN  = 1'b0;
    localparam logic PTR_EDIT = 1'b1;
    localparam logic [AW:0] ROWS_L = (AW+1)'(ROWS);

    state_t        state_q, state_d;
    logic          ptr_q, ptr_d;
    logic          init_ack_q, gen_ack_q, edit_ack_q;
    logic          wr_en_q;
    logic [AW-1:0] wr_addr_q;
    logic [DW-1:0] wr_data_q;
    logic          addr_err_q;

    logic          gnt_init, gnt_gen, gnt_edit;
    logic          gen_elig, edit_elig;
    logic          win, in_range;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_data;

    // Select this cycle's winner and the next state
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_init  = 1'b0;
        gnt_gen   = 1'b0;
        gnt_edit  = 1'b0;
        gen_elig  = 1'b0;
        edit_elig = 1'b0;
        sel_addr  = '0;
        sel_data  = '0;

        if (state_q == S_INIT) begin
            gnt_init = init_req && !init_ack_q;
            if (init_done) state_d = S_RUN;
        end else if (!de) begin
            gen_elig  = gen_req && !gen_ack_q;
            edit_elig = edit_req && !edit_ack_q;
            if (gen_elig && edit_elig) begin
                gnt_gen  = (ptr_q == PTR_EDIT);
                gnt_edit = (ptr_q == PTR_GEN);
            end else begin
                gnt_gen  = gen_elig;
                gnt_edit = edit_elig;
            end
        end

        unique case (1'b1)
            gnt_init: begin
                sel_addr = init_addr;
                sel_data = init_data;
            end
            gnt_gen: begin
                sel_addr = gen_addr;
                sel_data = gen_data;
                ptr_d    = PTR_GEN;
            end
            gnt_edit: begin
                sel_addr = edit_addr;
                sel_data = edit_data;
                ptr_d    = PTR_EDIT;
            end
            default: ;
        endcase

        win      = gnt_init | gnt_gen | gnt_edit;
        in_range = {1'b0, sel_addr} < ROWS_L;
    end

    // Register acks, write port, pointer, state and sticky error
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_INIT;
            ptr_q      <= PTR_EDIT;
            init_ack_q <= 1'b0;
            gen_ack_q  <= 1'b0;
            edit_ack_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            init_ack_q <= gnt_init;
            gen_ack_q  <= gnt_gen;
            edit_ack_q <= gnt_edit;
            wr_en_q    <= win && in_range;
            if (win && in_range) begin
                wr_addr_q <= sel_addr;
                wr_data_q <= sel_data;
            end
            if (win && !in_range) addr_err_q <= 1'b1;
        end
    end

    assign init_ack = init_ack_q;
    assign gen_ack  = gen_ack_q;
    assign edit_ack = edit_ack_q;
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign init_rdy = (state_q == S_RUN);
    assign addr_err = addr_err_q;

endmodule

// File: tb/tb_fb_wr_arbiter.sv
// Scoreboard bench for fb_wr_arbiter: init phase, RUN arbitration,
// de gating, address errors and mid-operation reset.
module tb_fb_wr_arbiter;

    localparam int DW   = 100;
    localparam int AW   = 7;
    localparam int ROWS = 100;

    logic          clk = 1'b0;
    logic          rst;
    logic          de;
    logic          init_req, gen_req, edit_req;
    logic [AW-1:0] init_addr, gen_addr, edit_addr;
    logic [DW-1:0] init_data, gen_data, edit_data;
    logic          init_done;
    logic          init_ack, gen_ack, edit_ack;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          init_rdy;
    logic          addr_err;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [2:0]    acks;
        logic          en;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          sb[$];
    exp_t          e;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    logic [127:0]  rnd;

    fb_wr_arbiter #(.DW(DW), .AW(AW), .ROWS(ROWS)) dut (
        .clk(clk), .rst(rst), .de(de),
        .init_req(init_req), .gen_req(gen_req), .edit_req(edit_req),
        .init_addr(init_addr), .gen_addr(gen_addr), .edit_addr(edit_addr),
        .init_data(init_data), .gen_data(gen_data), .edit_data(edit_data),
        .init_done(init_done),
        .init_ack(init_ack), .gen_ack(gen_ack), .edit_ack(edit_ack),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .init_rdy(init_rdy), .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rdata();
        logic [127:0] t;
        t = {$urandom, $urandom, $urandom, $urandom};
        return t[DW-1:0];
    endfunction

    // Expected grant; write port model holds on out-of-range rows
    task automatic push_exp(input logic [2:0] acks,
                            input logic [AW-1:0] a,
                            input logic [DW-1:0] d);
        exp_t x;
        x.acks = acks;
        x.en   = (int'(a) < ROWS);
        if (x.en) begin
            m_addr = a;
            m_data = d;
        end
        x.addr = m_addr;
        x.data = m_data;
        sb.push_back(x);
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; de = 1'b1; init_done = 1'b0;
        init_req = 1'b1; gen_req = 1'b1; edit_req = 1'b1;
        init_addr = 7'd3; gen_addr = 7'd4; edit_addr = 7'd5;
        init_data = rdata(); gen_data = rdata(); edit_data = rdata();
        @(negedge clk);
        cyc();
        cyc();
        total++;
        if ({init_ack, gen_ack, edit_ack, wr_en, init_rdy, addr_err} !== 6'b0
            || wr_addr !== '0 || wr_data !== '0) begin
            bad++;
            $display("FAIL reset_outs acks=%b%b%b en=%b rdy=%b err=%b addr=%0d",
                     init_ack, gen_ack, edit_ack, wr_en, init_rdy, addr_err, wr_addr);
        end
        m_addr = '0;
        m_data = '0;
        init_req = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_init();
        gen_req = 1'b1; edit_req = 1'b1; de = 1'b1;
        for (int i = 0; i < ROWS; i++) begin
            init_req  = 1'b1;
            init_addr = AW'(i);
            init_data = rdata();
            push_exp(3'b100, init_addr, init_data);
            cyc();
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL init_sb empty at row %0d", i);
            end else begin
                e = sb.pop_front();
                if ({init_ack, gen_ack, edit_ack, wr_en, wr_addr, wr_data}
                    !== {e.acks, e.en, e.addr, e.data}) begin
                    bad++;
                    $display("FAIL init_row%0d acks=%b%b%b en=%b addr=%0d exp acks=%b en=%b addr=%0d data=%h/%h",
                             i, init_ack, gen_ack, edit_ack, wr_en, wr_addr,
                             e.acks, e.en, e.addr, wr_data, e.data);
                end
            end
            init_req = 1'b0;
            cyc();
            total++;
            if ({init_ack, gen_ack, edit_ack, wr_en} !== 4'b0) begin
                bad++;
                $display("FAIL init_gap%0d acks=%b%b%b en=%b exp 0",
                         i, init_ack, gen_ack, edit_ack, wr_en);
            end
        end
        gen_req = 1'b0;
        edit_req = 1'b0;
    endtask

    task automatic test_init_done();
        total++;
        if (init_rdy !== 1'b0) begin
            bad++;
            $display("FAIL rdy_before got=%b exp=0", init_rdy);
        end
        init_done = 1'b1;
        cyc();
        init_done = 1'b0;
        total++;
        if (init_rdy !== 1'b1) begin
            bad++;
            $display("FAIL rdy_after got=%b exp=1", init_rdy);
        end
        de = 1'b0;
        init_req = 1'b1;
        init_addr = 7'd9;
        init_data = rdata();
        for (int k = 0; k < 3; k++) begin
            cyc();
            total++;
            if (init_ack !== 1'b0 || wr_en !== 1'b0) begin
                bad++;
                $display("FAIL run_init_ignored ack=%b en=%b exp 0 0", init_ack, wr_en);
            end
        end
        init_req = 1'b0;
    endtask

    task automatic test_round_robin();
        de = 1'b0;
        gen_addr = 7'd10; gen_data = rdata();
        edit_addr = 7'd20; edit_data = rdata();
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0) push_exp(3'b010, gen_addr, gen_data);
            else push_exp(3'b001, edit_addr, edit_data);
        end
        gen_req = 1'b1;
        edit_req = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cyc();
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL rr_sb empty k=%0d", k);
            end else begin
                e = sb.pop_front();
                if ({init_ack, gen_ack, edit_ack, wr_en, wr_addr, wr_data}
                    !== {e.acks, e.en, e.addr, e.data}) begin
                    bad++;
                    $display("FAIL rr_grant%0d acks=%b%b%b en=%b addr=%0d exp acks=%b en=%b addr=%0d",
                             k, init_ack, gen_ack, edit_ack, wr_en, wr_addr,
                             e.acks, e.en, e.addr);
                end
            end
        end
        gen_req = 1'b0;
        edit_req = 1'b0;
        cyc();
        total++;
        if ({gen_ack, edit_ack, wr_en} !== 3'b0) begin
            bad++;
            $display("FAIL rr_idle acks=%b%b en=%b exp 0", gen_ack, edit_ack, wr_en);
        end
    endtask

    task automatic test_back_to_back();
        gen_addr = 7'd11;
        gen_data = rdata();
        gen_req = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (k % 2 == 0) push_exp(3'b010, gen_addr, gen_data);
            cyc();
            total++;
            if (k % 2 == 0) begin
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL hold_sb empty k=%0d", k);
                end else begin
                    e = sb.pop_front();
                    if ({init_ack, gen_ack, edit_ack, wr_en, wr_addr, wr_data}
                        !== {e.acks, e.en, e.addr, e.data}) begin
                        bad++;
                        $display("FAIL hold_grant%0d acks=%b%b%b en=%b addr=%0d exp acks=%b en=%b addr=%0d",
                                 k, init_ack, gen_ack, edit_ack, wr_en, wr_addr,
                                 e.acks, e.en, e.addr);
                    end
                end
            end else if (gen_ack !== 1'b0 || wr_en !== 1'b0) begin
                bad++;
                $display("FAIL hold_gap%0d ack=%b en=%b exp 0 0", k, gen_ack, wr_en);
            end
        end
        gen_req = 1'b0;
        cyc();
    endtask

    task automatic test_de_block();
        gen_addr = 7'd12;
        gen_data = rdata();
        gen_req = 1'b1;
        de = 1'b1;
        for (int k = 0; k < 10; k++) begin
            cyc();
            total++;
            if (gen_ack !== 1'b0 || wr_en !== 1'b0) begin
                bad++;
                $display("FAIL de_block%0d ack=%b en=%b exp 0 0", k, gen_ack, wr_en);
            end
        end
        de = 1'b0;
        push_exp(3'b010, gen_addr, gen_data);
        @(posedge clk);
        #1 de = 1'b1;
        @(negedge clk);
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL de_sb empty");
        end else begin
            e = sb.pop_front();
            if ({init_ack, gen_ack, edit_ack, wr_en, wr_addr, wr_data}
                !== {e.acks, e.en, e.addr, e.data}) begin
                bad++;
                $display("FAIL de_release acks=%b%b%b en=%b addr=%0d exp acks=%b en=%b addr=%0d",
                         init_ack, gen_ack, edit_ack, wr_en, wr_addr,
                         e.acks, e.en, e.addr);
            end
        end
        gen_req = 1'b0;
        de = 1'b0;
        cyc();
    endtask

    task automatic test_addr_err();
        logic [AW-1:0] eaddr [3];
        logic [2:0]    who   [3];
        eaddr = '{7'd99, 7'd100, 7'd50};
        who   = '{3'b001, 3'b001, 3'b010};
        total++;
        if (addr_err !== 1'b0) begin
            bad++;
            $display("FAIL err_pre got=%b exp=0", addr_err);
        end
        de = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (who[k] == 3'b001) begin
                edit_addr = eaddr[k]; edit_data = rdata(); edit_req = 1'b1;
                push_exp(who[k], edit_addr, edit_data);
            end else begin
                gen_addr = eaddr[k]; gen_data = rdata(); gen_req = 1'b1;
                push_exp(who[k], gen_addr, gen_data);
            end
            cyc();
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL err_sb empty k=%0d", k);
            end else begin
                e = sb.pop_front();
                if ({init_ack, gen_ack, edit_ack, wr_en, wr_addr, wr_data, addr_err}
                    !== {e.acks, e.en, e.addr, e.data, k != 0}) begin
                    bad++;
                    $display("FAIL err_wr%0d acks=%b%b%b en=%b addr=%0d err=%b exp acks=%b en=%b addr=%0d err=%b",
                             k, init_ack, gen_ack, edit_ack, wr_en, wr_addr, addr_err,
                             e.acks, e.en, e.addr, k != 0);
                end
            end
            edit_req = 1'b0;
            gen_req = 1'b0;
            for (int j = 0; j < 3; j++) cyc();
            total++;
            if (addr_err !== (k != 0)) begin
                bad++;
                $display("FAIL err_sticky%0d got=%b exp=%b", k, addr_err, k != 0);
            end
        end
    endtask

    task automatic test_rst_mid();
        de = 1'b0;
        gen_addr = 7'd30;
        gen_data = rdata();
        gen_req = 1'b1;
        push_exp(3'b010, gen_addr, gen_data);
        cyc();
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL rst_sb empty");
        end else begin
            e = sb.pop_front();
            if ({gen_ack, wr_en, wr_addr} !== {1'b1, e.en, e.addr}) begin
                bad++;
                $display("FAIL rst_pre_ack ack=%b en=%b addr=%0d exp 1 %b %0d",
                         gen_ack, wr_en, wr_addr, e.en, e.addr);
            end
        end
        rst = 1'b1;
        cyc();
        total++;
        if ({init_ack, gen_ack, edit_ack, wr_en, init_rdy, addr_err} !== 6'b0
            || wr_addr !== '0 || wr_data !== '0) begin
            bad++;
            $display("FAIL rst_mid acks=%b%b%b en=%b rdy=%b err=%b addr=%0d",
                     init_ack, gen_ack, edit_ack, wr_en, init_rdy, addr_err, wr_addr);
        end
        m_addr = '0;
        m_data = '0;
        rst = 1'b0;
        edit_addr = 7'd31;
        edit_data = rdata();
        edit_req = 1'b1;
        cyc();
        total++;
        if ({gen_ack, edit_ack, wr_en, init_rdy} !== 4'b0) begin
            bad++;
            $display("FAIL rst_init_ignores acks=%b%b en=%b rdy=%b exp 0",
                     gen_ack, edit_ack, wr_en, init_rdy);
        end
        init_req = 1'b1;
        init_addr = 7'd42;
        init_data = rdata();
        init_done = 1'b1;
        push_exp(3'b100, init_addr, init_data);
        push_exp(3'b010, gen_addr, gen_data);
        cyc();
        init_req = 1'b0;
        init_done = 1'b0;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL coinc_sb empty");
        end else begin
            e = sb.pop_front();
            if ({init_ack, gen_ack, edit_ack, wr_en, wr_addr, wr_data, init_rdy}
                !== {e.acks, e.en, e.addr, e.data, 1'b1}) begin
                bad++;
                $display("FAIL coinc_done acks=%b%b%b en=%b addr=%0d rdy=%b exp acks=%b en=%b addr=%0d rdy=1",
                         init_ack, gen_ack, edit_ack, wr_en, wr_addr, init_rdy,
                         e.acks, e.en, e.addr);
            end
        end
        cyc();
        gen_req = 1'b0;
        edit_req = 1'b0;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL ptr_sb empty");
        end else begin
            e = sb.pop_front();
            if ({init_ack, gen_ack, edit_ack, wr_en, wr_addr, wr_data}
                !== {e.acks, e.en, e.addr, e.data}) begin
                bad++;
                $display("FAIL ptr_reset acks=%b%b%b en=%b addr=%0d exp acks=%b en=%b addr=%0d",
                         init_ack, gen_ack, edit_ack, wr_en, wr_addr,
                         e.acks, e.en, e.addr);
            end
        end
        cyc();
        cyc();
    endtask

    initial begin
        rnd = '0;
        test_reset();
        test_init();
        test_init_done();
        test_round_robin();
        test_back_to_back();
        test_de_block();
        test_addr_err();
        test_rst_mid();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover got=%0d exp=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
